// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder.
// Holds the default slice width, FSM states and index-width helper.
package cla_pkg;

    localparam int SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int idx_w(input int width, input int slice);
        int n;
        n = width / slice;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead slice.
// Exposes the carry into the MSB for signed-overflow detection.
module cla_slice
    import cla_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             t;
    logic             pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of generate terms, not a ripple chain.
    always_comb begin
        c    = '0;
        t    = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & cin);
        end
    end

    assign sum   = p ^ c[SLICE-1:0];
    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_adder_seq.sv
// Multi-cycle add/subtract using one CLA slice per clock.
// Define CLA_ADDER_SEQ_OVF_EN to enable signed-overflow output.
module cla_adder_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] Output,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = idx_w(WIDTH, SLICE);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             carry_q;
    logic             sub_q;
    logic             start;
    logic             last;
    int               base;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             msb_carry;
    logic             sig_unused;

    assign start = en && (state != RUN);
    assign last  = (idx == LAST);
    assign busy  = (state == RUN);
    assign base  = int'(idx) * SLICE;

    cla_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a    (a_q[base +: SLICE]),
        .b    (b_q[base +: SLICE]),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout),
        .c_msb(msb_carry)
    );

    always_comb begin
        acc_nx = acc;
        acc_nx[base +: SLICE] = s_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = en ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = en ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is folded in at capture: B inverted, carry forced to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            Output  <= '0;
            c_out   <= 1'b0;
            ready   <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (start) begin
                a_q     <= A;
                b_q     <= sub ? ~B : B;
                carry_q <= sub | c_in;
                sub_q   <= sub;
                idx     <= '0;
            end else if (state == RUN) begin
                acc     <= acc_nx;
                carry_q <= s_cout;
                idx     <= last ? '0 : idx + 1'b1;
                if (last) begin
                    Output <= acc_nx;
                    c_out  <= s_cout;
                    ready  <= 1'b1;
                end
            end
        end
    end

`ifdef CLA_ADDER_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (!start && state == RUN && last) begin
            overflow <= msb_carry ^ s_cout;
        end
    end

    assign sig_unused = sub_q;
`else
    assign overflow   = 1'b0;
    assign sig_unused = sub_q ^ msb_carry;
`endif

endmodule

// File: tb/tb_cla_adder_seq.sv
// Randomised self-checking bench for cla_adder_seq at widths 8, 16 and 4.
// All three instances share stimulus; a reference model predicts each.
module tb_cla_adder_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sub;
    logic        cin;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic        busy [3];
    logic        rdy  [3];
    logic        co   [3];
    logic        ov   [3];
    logic [7:0]  o8;
    logic [15:0] o16;
    logic [3:0]  o4;
    logic [15:0] outs [3];

    int WD [3] = '{8, 16, 4};
    int ND [3] = '{2, 4, 1};

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_on = 0;

    cla_adder_seq #(.WIDTH(8), .SLICE(4)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .c_in(cin),
        .A(a_in[7:0]), .B(b_in[7:0]),
        .busy(busy[0]), .ready(rdy[0]), .Output(o8),
        .c_out(co[0]), .overflow(ov[0])
    );

    cla_adder_seq #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .c_in(cin),
        .A(a_in), .B(b_in),
        .busy(busy[1]), .ready(rdy[1]), .Output(o16),
        .c_out(co[1]), .overflow(ov[1])
    );

    cla_adder_seq #(.WIDTH(4), .SLICE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sub(sub), .c_in(cin),
        .A(a_in[3:0]), .B(b_in[3:0]),
        .busy(busy[2]), .ready(rdy[2]), .Output(o4),
        .c_out(co[2]), .overflow(ov[2])
    );

    always_comb begin
        outs[0] = {8'h00, o8};
        outs[1] = o16;
        outs[2] = {12'h000, o4};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a countdown of cycles to completion per instance.
    int          rem   [3] = '{0, 0, 0};
    logic        m_rdy [3] = '{0, 0, 0};
    logic        m_co  [3] = '{0, 0, 0};
    logic        m_ov  [3] = '{0, 0, 0};
    logic [15:0] m_out [3] = '{0, 0, 0};
    logic        p_co  [3];
    logic        p_ov  [3];
    logic [15:0] p_out [3];

    always @(posedge clk or negedge rst_n) begin
        longint unsigned mask, msb, av, bv, fl;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                rem[d]   = 0;
                m_rdy[d] = 1'b0;
                m_co[d]  = 1'b0;
                m_ov[d]  = 1'b0;
                m_out[d] = '0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (rem[d] > 0) begin
                    rem[d]--;
                    m_rdy[d] = (rem[d] == 0);
                    if (m_rdy[d]) begin
                        m_out[d] = p_out[d];
                        m_co[d]  = p_co[d];
                        m_ov[d]  = p_ov[d];
                    end
                end else begin
                    m_rdy[d] = 1'b0;
                    if (en) begin
                        mask = (64'd1 << WD[d]) - 1;
                        msb  = 64'd1 << (WD[d] - 1);
                        av   = 64'(a_in) & mask;
                        bv   = 64'(sub ? ~b_in : b_in) & mask;
                        fl   = av + bv + 64'(sub | cin);
                        p_out[d] = 16'(fl & mask);
                        p_co[d]  = ((fl >> WD[d]) & 1) != 0;
`ifdef CLA_ADDER_SEQ_OVF_EN
                        p_ov[d]  = ((av & msb) == (bv & msb)) &&
                                   ((fl & msb) != (av & msb));
`else
                        p_ov[d]  = 1'b0;
`endif
                        rem[d] = ND[d];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("w%0d.busy", WD[d]), 64'(busy[d]), 64'(rem[d] > 0));
                chk($sformatf("w%0d.ready", WD[d]), 64'(rdy[d]), 64'(m_rdy[d]));
                chk($sformatf("w%0d.out", WD[d]), 64'(outs[d]), 64'(m_out[d]));
                chk($sformatf("w%0d.c_out", WD[d]), 64'(co[d]), 64'(m_co[d]));
                chk($sformatf("w%0d.ovf", WD[d]), 64'(ov[d]), 64'(m_ov[d]));
            end
        end
    end

    task automatic run_op(input logic s, input logic c,
                          input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        en = 1'b1; sub = s; cin = c; a_in = a; b_in = b;
        @(negedge clk);
        en = 1'b0; sub = $urandom; cin = $urandom;
        a_in = 16'($urandom); b_in = 16'($urandom);
        repeat (5) @(negedge clk);
    endtask

    localparam logic OVF_ON =
`ifdef CLA_ADDER_SEQ_OVF_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        int last_rdy;
        int pulses;
        rst_n = 1'b0; en = 1'b0; sub = 1'b0; cin = 1'b0;
        a_in = '0; b_in = '0;
        @(negedge clk);
        chk("rst.out8", 64'(o8), 64'h0);
        chk("rst.busy8", 64'(busy[0]), 64'h0);
        chk("rst.ready8", 64'(rdy[0]), 64'h0);
        chk("rst.out16", 64'(o16), 64'h0);
        cmp_on = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        en = 1'b1; a_in = 16'd1; b_in = 16'd2;
        @(negedge clk);
        en = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
        chk("lat.busy8_c1", 64'(busy[0]), 64'h1);
        chk("lat.ready8_c1", 64'(rdy[0]), 64'h0);
        @(negedge clk);
        chk("lat.ready4", 64'(rdy[2]), 64'h1);
        chk("lat.out4", 64'(o4), 64'h3);
        chk("lat.busy8_c2", 64'(busy[0]), 64'h1);
        chk("lat.ready8_c2", 64'(rdy[0]), 64'h0);
        @(negedge clk);
        chk("lat.ready8", 64'(rdy[0]), 64'h1);
        chk("lat.out8", 64'(o8), 64'h03);
        chk("lat.cout8", 64'(co[0]), 64'h0);
        chk("lat.busy8_c3", 64'(busy[0]), 64'h0);
        @(negedge clk);
        chk("lat.pulse8", 64'(rdy[0]), 64'h0);

        run_op(1'b0, 1'b1, 16'h00FF, 16'h0001);
        chk("add.ff_out", 64'(o8), 64'h01);
        chk("add.ff_cout", 64'(co[0]), 64'h1);
        chk("add.ff_ovf", 64'(ov[0]), 64'h0);

        run_op(1'b1, 1'b0, 16'h0010, 16'h0020);
        chk("sub.borrow_out", 64'(o8), 64'hF0);
        chk("sub.borrow_cout", 64'(co[0]), 64'h0);

        run_op(1'b1, 1'b1, 16'h007F, 16'h00FF);
        chk("sub.ovf_out", 64'(o8), 64'h80);
        chk("sub.ovf_flag", 64'(ov[0]), 64'(OVF_ON));

        run_op(1'b0, 1'b0, 16'h0009, 16'h0008);
        chk("n1.out4", 64'(o4), 64'h1);
        chk("n1.cout4", 64'(co[2]), 64'h1);

        @(negedge clk);
        en = 1'b1; sub = 1'b0; cin = 1'b0;
        a_in = 16'h1234; b_in = 16'h4321;
        last_rdy = -1;
        pulses = 0;
        for (int cyc = 0; cyc < 26; cyc++) begin
            @(negedge clk);
            if (rdy[1]) begin
                if (last_rdy >= 0) chk("b2b.gap16", 64'(cyc - last_rdy), 64'd5);
                chk("b2b.out16", 64'(o16), 64'h5555);
                last_rdy = cyc;
                pulses++;
            end
        end
        chk("b2b.pulses16", 64'(pulses), 64'd5);
        en = 1'b0;
        repeat (6) @(negedge clk);

        en = 1'b1; a_in = 16'h0F0F; b_in = 16'h0101;
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.out16", 64'(o16), 64'h0);
        chk("abort.busy16", 64'(busy[1]), 64'h0);
        chk("abort.ready16", 64'(rdy[1]), 64'h0);
        chk("abort.out8", 64'(o8), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 16'h1234, 16'h4321);
        chk("abort.next16", 64'(o16), 64'h5555);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            en   = ($urandom_range(0, 2) == 0);
            sub  = $urandom;
            cin  = $urandom;
            a_in = 16'($urandom);
            b_in = 16'($urandom);
        end
        en = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
